// File: rtl/snitch_icache_lookup_banked.sv
// rtl/snitch_icache_lookup_banked.sv - banked multi-port L1 icache tag/data lookup
// Purpose: serves NR_PORTS fetch lookups against a set-associative store whose sets
//   are interleaved over NR_BANKS single-ported banks; per-bank round-robin read
//   arbitration, refill writes take priority, 2-entry fall-through output FIFO per port.
// Ports: clk_i/rst_ni clock and async active-low reset; flush_valid_i/flush_ready_o
//   flush handshake; in_* per-port lookup requests; out_* per-port responses;
//   write_* refill port; hit_o/miss_o/conflict_o per-port event pulses.
module snitch_icache_lookup_banked #(
   parameter int unsigned NR_PORTS   = 2,
   parameter int unsigned NR_BANKS   = 2,
   parameter int unsigned WAY_COUNT  = 4,
   parameter int unsigned LINE_COUNT = 128,
   parameter int unsigned LINE_WIDTH = 128,
   parameter int unsigned LINE_ALIGN = 4,
   parameter int unsigned FETCH_AW   = 32,
   parameter int unsigned ID_WIDTH   = 4,
   localparam int unsigned COUNT_ALIGN = $clog2(LINE_COUNT),
   localparam int unsigned BANK_ALIGN  = $clog2(NR_BANKS),
   localparam int unsigned DEPTH       = LINE_COUNT / NR_BANKS,
   localparam int unsigned TAG_WIDTH   = FETCH_AW - LINE_ALIGN - COUNT_ALIGN,
   localparam int unsigned WAY_ALIGN   = (WAY_COUNT > 1) ? $clog2(WAY_COUNT) : 1
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           flush_valid_i,
   output logic                           flush_ready_o,
   input  logic [NR_PORTS*FETCH_AW-1:0]   in_addr_i,
   input  logic [NR_PORTS*ID_WIDTH-1:0]   in_id_i,
   input  logic [NR_PORTS-1:0]            in_valid_i,
   output logic [NR_PORTS-1:0]            in_ready_o,
   output logic [NR_PORTS*FETCH_AW-1:0]   out_addr_o,
   output logic [NR_PORTS*ID_WIDTH-1:0]   out_id_o,
   output logic [NR_PORTS*WAY_ALIGN-1:0]  out_way_o,
   output logic [NR_PORTS-1:0]            out_hit_o,
   output logic [NR_PORTS-1:0]            out_error_o,
   output logic [NR_PORTS*LINE_WIDTH-1:0] out_data_o,
   output logic [NR_PORTS-1:0]            out_valid_o,
   input  logic [NR_PORTS-1:0]            out_ready_i,
   input  logic [COUNT_ALIGN-1:0]         write_addr_i,
   input  logic [WAY_ALIGN-1:0]           write_way_i,
   input  logic [LINE_WIDTH-1:0]          write_data_i,
   input  logic [TAG_WIDTH-1:0]           write_tag_i,
   input  logic                           write_error_i,
   input  logic                           write_valid_i,
   output logic                           write_ready_o,
   output logic [NR_PORTS-1:0]            hit_o,
   output logic [NR_PORTS-1:0]            miss_o,
   output logic [NR_PORTS-1:0]            conflict_o
);
   localparam int unsigned BANK_W = (BANK_ALIGN > 0) ? BANK_ALIGN : 1;
   localparam int unsigned ROW_W  = (COUNT_ALIGN > BANK_ALIGN) ? (COUNT_ALIGN - BANK_ALIGN) : 1;
   localparam int unsigned PORT_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
   localparam int unsigned TAGW   = TAG_WIDTH + 2;   // {valid, error, tag}

   typedef enum logic {SWEEP, IDLE} state_e;
   typedef struct packed {
      logic [FETCH_AW-1:0]   addr;
      logic [ID_WIDTH-1:0]   id;
      logic [WAY_ALIGN-1:0]  way;
      logic                  hit;
      logic                  err;
      logic [LINE_WIDTH-1:0] data;
   } resp_t;

   // Masking keeps the single-bank case at bank 0 without a zero-width slice.
   function automatic logic [BANK_W-1:0] bank_of(input logic [COUNT_ALIGN-1:0] set);
      logic [COUNT_ALIGN-1:0] m;
      m = set & COUNT_ALIGN'(NR_BANKS - 1);
      return m[BANK_W-1:0];
   endfunction

   function automatic logic [ROW_W-1:0] row_of(input logic [COUNT_ALIGN-1:0] set);
      logic [COUNT_ALIGN-1:0] m;
      m = set >> BANK_ALIGN;
      return m[ROW_W-1:0];
   endfunction

   logic [LINE_WIDTH-1:0] r_data_mem [NR_BANKS][WAY_COUNT][DEPTH];
   logic [TAGW-1:0]       r_tag_mem  [NR_BANKS][WAY_COUNT][DEPTH];
   logic [LINE_WIDTH-1:0] r_data_q   [NR_BANKS][WAY_COUNT];
   logic [TAGW-1:0]       r_tag_q    [NR_BANKS][WAY_COUNT];

   state_e             r_state, w_state_next;
   logic [ROW_W-1:0]   r_cnt, w_cnt_next;
   logic               w_sweep, w_idle, w_wfire;
   logic [BANK_W-1:0]  w_wbank;
   logic [ROW_W-1:0]   w_wrow;

   logic [BANK_W-1:0]  w_req_bank [NR_PORTS];
   logic [ROW_W-1:0]   w_req_row  [NR_PORTS];
   logic [NR_PORTS-1:0] w_credit, w_pop, w_gnt, w_store, w_deq, w_out_valid;
   logic [NR_BANKS-1:0] w_ren;
   logic [ROW_W-1:0]   w_rrow [NR_BANKS];
   logic [PORT_W-1:0]  r_ptr [NR_BANKS];
   logic [PORT_W-1:0]  w_ptr_next [NR_BANKS];

   logic [NR_PORTS-1:0] r_s1_valid;
   logic [FETCH_AW-1:0] r_s1_addr [NR_PORTS];
   logic [ID_WIDTH-1:0] r_s1_id   [NR_PORTS];
   logic [BANK_W-1:0]   r_s1_bank [NR_PORTS];
   resp_t               w_s1_resp [NR_PORTS];

   resp_t               r_fifo [NR_PORTS][2];
   logic [NR_PORTS-1:0] r_rd_ptr, r_wr_ptr;
   logic [1:0]          r_usage [NR_PORTS];
   resp_t               w_out [NR_PORTS];

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_sweep      = 1'b0;
      w_idle       = 1'b0;
      case (r_state)
         SWEEP: begin
            w_sweep    = 1'b1;
            w_cnt_next = r_cnt + ROW_W'(1);
            if (r_cnt == ROW_W'(DEPTH - 1)) begin
               w_state_next = IDLE;
               w_cnt_next   = '0;
            end
         end
         IDLE: begin
            w_idle = 1'b1;
            if (flush_valid_i) begin
               w_state_next = SWEEP;
               w_cnt_next   = '0;
            end
         end
         default: ;
      endcase
   end

   assign flush_ready_o = w_idle;
   assign write_ready_o = w_idle;
   assign w_wfire       = w_idle & write_valid_i;
   assign w_wbank       = bank_of(write_addr_i);
   assign w_wrow        = row_of(write_addr_i);

   // Credit counts the S1 slot too, so a granted lookup always has FIFO room.
   always_comb begin
      w_credit = '0;
      for (int p = 0; p < NR_PORTS; p++) begin
         w_req_bank[p] = bank_of(in_addr_i[p*FETCH_AW+LINE_ALIGN +: COUNT_ALIGN]);
         w_req_row[p]  = row_of(in_addr_i[p*FETCH_AW+LINE_ALIGN +: COUNT_ALIGN]);
         w_credit[p]   = (32'(r_s1_valid[p]) + 32'(r_usage[p])) < (32'd2 + 32'(w_pop[p]));
      end
   end

   // Per bank: first eligible port at or after the pointer wins.
   always_comb begin
      w_gnt = '0;
      w_ren = '0;
      for (int b = 0; b < NR_BANKS; b++) begin
         w_rrow[b]     = '0;
         w_ptr_next[b] = r_ptr[b];
         for (int k = 0; k < NR_PORTS; k++) begin
            for (int p = 0; p < NR_PORTS; p++) begin
               if (!w_ren[b] && ((int'(r_ptr[b]) + k) % int'(NR_PORTS) == p) &&
                   w_idle && in_valid_i[p] && w_credit[p] &&
                   (w_req_bank[p] == BANK_W'(b)) &&
                   !(w_wfire && (w_wbank == BANK_W'(b)))) begin
                  w_ren[b]      = 1'b1;
                  w_gnt[p]      = 1'b1;
                  w_rrow[b]     = w_req_row[p];
                  w_ptr_next[b] = PORT_W'((p + 1) % int'(NR_PORTS));
               end
            end
         end
      end
   end

   assign in_ready_o = w_gnt;
   assign conflict_o = {NR_PORTS{w_idle}} & in_valid_i & w_credit & ~w_gnt;

   // Bank storage: latency-1 reads; reads and writes never share a bank in one cycle.
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < NR_BANKS; b++) begin
         for (int w = 0; w < WAY_COUNT; w++) begin
            if (w_sweep) begin
               r_tag_mem[b][w][r_cnt]  <= '0;
               r_data_mem[b][w][r_cnt] <= '0;
            end else if (w_wfire && (w_wbank == BANK_W'(b)) && (write_way_i == WAY_ALIGN'(w))) begin
               r_tag_mem[b][w][w_wrow]  <= {1'b1, write_error_i, write_tag_i};
               r_data_mem[b][w][w_wrow] <= write_data_i;
            end
            if (w_ren[b]) begin
               r_tag_q[b][w]  <= r_tag_mem[b][w][w_rrow[b]];
               r_data_q[b][w] <= r_data_mem[b][w][w_rrow[b]];
            end
         end
      end
   end

   // Iterating from the top way down leaves the lowest hit way's index and error.
   always_comb begin
      for (int p = 0; p < NR_PORTS; p++) begin
         w_s1_resp[p]      = '0;
         w_s1_resp[p].addr = r_s1_addr[p];
         w_s1_resp[p].id   = r_s1_id[p];
         for (int w = int'(WAY_COUNT) - 1; w >= 0; w--) begin
            if (r_tag_q[r_s1_bank[p]][w][TAGW-1] &&
                (r_tag_q[r_s1_bank[p]][w][TAG_WIDTH-1:0] == r_s1_addr[p][FETCH_AW-1 -: TAG_WIDTH])) begin
               w_s1_resp[p].hit  = 1'b1;
               w_s1_resp[p].way  = WAY_ALIGN'(w);
               w_s1_resp[p].err  = r_tag_q[r_s1_bank[p]][w][TAG_WIDTH];
               w_s1_resp[p].data = w_s1_resp[p].data | r_data_q[r_s1_bank[p]][w];
            end
         end
      end
   end

   // Fall-through FIFO: an S1 result popped straight through is never stored.
   always_comb begin
      for (int p = 0; p < NR_PORTS; p++) begin
         w_out_valid[p] = (r_usage[p] != 2'd0) | r_s1_valid[p];
         w_pop[p]       = w_out_valid[p] & out_ready_i[p];
         w_deq[p]       = (r_usage[p] != 2'd0) & out_ready_i[p];
         w_store[p]     = r_s1_valid[p] & ~((r_usage[p] == 2'd0) & out_ready_i[p]);
         if (r_usage[p] != 2'd0)  w_out[p] = r_fifo[p][r_rd_ptr[p]];
         else if (r_s1_valid[p])  w_out[p] = w_s1_resp[p];
         else                     w_out[p] = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= SWEEP;
         r_cnt      <= '0;
         r_s1_valid <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         for (int b = 0; b < NR_BANKS; b++) r_ptr[b] <= '0;
         for (int p = 0; p < NR_PORTS; p++) begin
            r_s1_addr[p] <= '0;
            r_s1_id[p]   <= '0;
            r_s1_bank[p] <= '0;
            r_usage[p]   <= '0;
            r_fifo[p][0] <= '0;
            r_fifo[p][1] <= '0;
         end
      end else begin
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
         r_s1_valid <= w_gnt;
         for (int b = 0; b < NR_BANKS; b++) r_ptr[b] <= w_ptr_next[b];
         for (int p = 0; p < NR_PORTS; p++) begin
            r_s1_addr[p] <= in_addr_i[p*FETCH_AW +: FETCH_AW];
            r_s1_id[p]   <= in_id_i[p*ID_WIDTH +: ID_WIDTH];
            r_s1_bank[p] <= w_req_bank[p];
            if (w_store[p]) begin
               r_fifo[p][r_wr_ptr[p]] <= w_s1_resp[p];
               r_wr_ptr[p]            <= ~r_wr_ptr[p];
            end
            if (w_deq[p]) r_rd_ptr[p] <= ~r_rd_ptr[p];
            r_usage[p] <= r_usage[p] + {1'b0, w_store[p]} - {1'b0, w_deq[p]};
         end
      end
   end

   for (genvar p = 0; p < NR_PORTS; p++) begin : g_out
      assign out_addr_o[p*FETCH_AW +: FETCH_AW]     = w_out[p].addr;
      assign out_id_o[p*ID_WIDTH +: ID_WIDTH]       = w_out[p].id;
      assign out_way_o[p*WAY_ALIGN +: WAY_ALIGN]    = w_out[p].way;
      assign out_hit_o[p]                           = w_out[p].hit;
      assign out_error_o[p]                         = w_out[p].err;
      assign out_data_o[p*LINE_WIDTH +: LINE_WIDTH] = w_out[p].data;
      assign out_valid_o[p]                         = w_out_valid[p];
      assign hit_o[p]                               = r_s1_valid[p] & w_s1_resp[p].hit;
      assign miss_o[p]                              = r_s1_valid[p] & ~w_s1_resp[p].hit;
   end

endmodule

// File: tb/tb_snitch_icache_lookup_banked.sv
// tb/tb_snitch_icache_lookup_banked.sv - directed bench for snitch_icache_lookup_banked
module tb_snitch_icache_lookup_banked;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         flush_valid = 1'b0;
   logic         flush_ready;
   logic [63:0]  in_addr = '0;
   logic [7:0]   in_id = '0;
   logic [1:0]   in_valid = '0;
   logic [1:0]   in_ready;
   logic [63:0]  out_addr;
   logic [7:0]   out_id;
   logic [3:0]   out_way;
   logic [1:0]   out_hit, out_error, out_valid;
   logic [255:0] out_data;
   logic [1:0]   out_ready = 2'b11;
   logic [6:0]   write_addr = '0;
   logic [1:0]   write_way = '0;
   logic [127:0] write_data = '0;
   logic [20:0]  write_tag = '0;
   logic         write_error = 1'b0;
   logic         write_valid = 1'b0;
   logic         write_ready;
   logic [1:0]   hit, miss, conflict;

   int total = 0;
   int bad = 0;

   localparam logic [127:0] D_A5   = {16{8'hA5}};
   localparam logic [127:0] D_BEEF = {4{32'hDEADBEEF}};
   localparam logic [127:0] D_0123 = {4{32'h01234567}};

   always #5 clk = ~clk;

   snitch_icache_lookup_banked dut (
      .clk_i(clk), .rst_ni(rst_n),
      .flush_valid_i(flush_valid), .flush_ready_o(flush_ready),
      .in_addr_i(in_addr), .in_id_i(in_id), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .out_addr_o(out_addr), .out_id_o(out_id), .out_way_o(out_way), .out_hit_o(out_hit),
      .out_error_o(out_error), .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .write_addr_i(write_addr), .write_way_i(write_way), .write_data_i(write_data),
      .write_tag_i(write_tag), .write_error_i(write_error), .write_valid_i(write_valid),
      .write_ready_o(write_ready),
      .hit_o(hit), .miss_o(miss), .conflict_o(conflict)
   );

   function automatic logic [31:0] mk(input logic [20:0] tag, input logic [6:0] set);
      return {tag, set, 4'h0};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lookup(input int p, input logic [31:0] a, input logic [3:0] id, input logic ehit,
                         input logic [1:0] eway, input logic eerr, input logic [127:0] edata);
      in_addr[p*32 +: 32] = a;
      in_id[p*4 +: 4]     = id;
      in_valid[p]         = 1'b1;
      #4 check("lk_grant", in_ready[p], 1);
      tick();
      in_valid[p] = 1'b0;
      #4;
      check("lk_out_valid", out_valid[p], 1);
      check("lk_hit", out_hit[p], ehit);
      check("lk_error", out_error[p], eerr);
      check("lk_data", out_data[p*128 +: 128], edata);
      check("lk_id", out_id[p*4 +: 4], id);
      check("lk_addr", out_addr[p*32 +: 32], a);
      check("lk_hit_pulse", hit[p], ehit);
      check("lk_miss_pulse", miss[p], !ehit);
      if (ehit) check("lk_way", out_way[p*2 +: 2], eway);
      tick();
   endtask

   task automatic do_write(input logic [6:0] set, input logic [1:0] way, input logic [20:0] tag,
                           input logic [127:0] data, input logic err);
      write_addr  = set;
      write_way   = way;
      write_tag   = tag;
      write_data  = data;
      write_error = err;
      write_valid = 1'b1;
      #4 check("wr_ready", write_ready, 1);
      tick();
      write_valid = 1'b0;
   endtask

   initial begin
      int n;
      int n0;
      int n1;
      int pp;
      int g;

      // reset values
      in_valid = 2'b11;
      repeat (3) tick();
      #4;
      check("rst_in_ready", in_ready, 0);
      check("rst_write_ready", write_ready, 0);
      check("rst_flush_ready", flush_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data[127:0] | out_data[255:128], 0);
      check("rst_hit", hit, 0);
      check("rst_miss", miss, 0);
      check("rst_conflict", conflict, 0);
      tick();

      // initial sweep length
      in_valid = 2'b01;
      rst_n    = 1'b1;
      n        = 0;
      while (flush_ready !== 1'b1 && n < 200) begin
         if (n == 10) begin
            check("sweep_in_ready", in_ready, 0);
            check("sweep_write_ready", write_ready, 0);
            check("sweep_conflict", conflict, 0);
            in_valid = 2'b00;
         end
         tick();
         n++;
      end
      check("reset_sweep_len", n, 64);

      // miss, refill, hit (read granted in the cycle after the write)
      lookup(0, mk(21'h1234, 7'd5), 4'h1, 1'b0, 2'd0, 1'b0, '0);
      do_write(7'd5, 2'd2, 21'h1234, D_A5, 1'b0);
      lookup(0, mk(21'h1234, 7'd5), 4'h2, 1'b1, 2'd2, 1'b0, D_A5);
      lookup(1, mk(21'h0055, 7'd7), 4'h3, 1'b0, 2'd0, 1'b0, '0);

      // both ports on bank 1: alternating grants, loser sees conflict
      in_addr[31:0]  = mk(21'h1234, 7'd5);
      in_addr[63:32] = mk(21'h0055, 7'd7);
      n0 = 0;
      n1 = 0;
      for (int c = 0; c <= 8; c++) begin
         in_valid = {n1 < 4, n0 < 4};
         in_id    = {4'(8 + n1), 4'(n0)};
         #4;
         if (c < 8) begin
            check("cf_ready", in_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
            check("cf_conflict", conflict, (c == 7) ? 2'b00 : ((c % 2 == 0) ? 2'b10 : 2'b01));
         end
         if (c > 0) begin
            pp = (c - 1) % 2;
            check("cf_out_valid", out_valid[pp], 1);
            check("cf_out_id", out_id[pp*4 +: 4], (pp == 1) ? 8 + (c - 1) / 2 : (c - 1) / 2);
            check("cf_out_hit", out_hit[pp], pp == 0);
         end
         if (c < 8) begin
            if (c % 2 == 0) n0++;
            else n1++;
         end
         tick();
      end
      in_valid = 2'b00;

      // write to bank 0 blocks port 0 for one cycle; port 1 on bank 1 proceeds
      in_addr[31:0]  = mk(21'h0042, 7'd4);
      in_addr[63:32] = mk(21'h0055, 7'd7);
      in_id          = 8'h54;
      in_valid       = 2'b11;
      write_addr     = 7'd6;
      write_way      = 2'd1;
      write_tag      = 21'h77;
      write_data     = D_BEEF;
      write_error    = 1'b0;
      write_valid    = 1'b1;
      #4;
      check("wr_vs_rd_write_ready", write_ready, 1);
      check("wr_vs_rd_in_ready", in_ready, 2'b10);
      check("wr_vs_rd_conflict", conflict, 2'b01);
      tick();
      write_valid = 1'b0;
      in_valid    = 2'b01;
      #4;
      check("wr_vs_rd_retry", in_ready, 2'b01);
      check("wr_vs_rd_p1_valid", out_valid[1], 1);
      check("wr_vs_rd_p1_id", out_id[7:4], 4'h5);
      tick();
      in_valid = 2'b00;
      #4;
      check("wr_vs_rd_p0_valid", out_valid[0], 1);
      check("wr_vs_rd_p0_id", out_id[3:0], 4'h4);
      check("wr_vs_rd_p0_hit", out_hit[0], 0);
      tick();
      lookup(0, mk(21'h77, 7'd6), 4'h6, 1'b1, 2'd1, 1'b0, D_BEEF);

      // backpressure: two grants, then stall; drain in order on release
      in_addr[31:0] = mk(21'h1234, 7'd5);
      out_ready     = 2'b10;
      in_valid      = 2'b01;
      g             = 0;
      for (int c = 0; c < 4; c++) begin
         in_id[3:0] = 4'(g);
         #4;
         check("bp_ready", in_ready[0], c < 2);
         if (c == 2) check("bp_conflict", conflict[0], 0);
         if (c >= 1) begin
            check("bp_stall_valid", out_valid[0], 1);
            check("bp_stall_id", out_id[3:0], 0);
         end
         if (c < 2) g++;
         tick();
      end
      in_valid  = 2'b00;
      out_ready = 2'b11;
      for (int c = 0; c < 3; c++) begin
         #4;
         if (c < 2) begin
            check("bp_drain_valid", out_valid[0], 1);
            check("bp_drain_id", out_id[3:0], c);
            check("bp_drain_data", out_data[127:0], D_A5);
         end else begin
            check("bp_drain_empty", out_valid[0], 0);
         end
         tick();
      end

      // error line, then flush clears it
      do_write(7'd9, 2'd0, 21'h0ABC, D_0123, 1'b1);
      lookup(1, mk(21'h0ABC, 7'd9), 4'h9, 1'b1, 2'd0, 1'b1, D_0123);
      flush_valid = 1'b1;
      #4 check("flush_ready", flush_ready, 1);
      tick();
      flush_valid    = 1'b0;
      in_addr[63:32] = mk(21'h0ABC, 7'd9);
      in_valid       = 2'b10;
      write_valid    = 1'b1;
      n              = 0;
      while (flush_ready !== 1'b1 && n < 200) begin
         if (n == 10) begin
            check("flush_in_ready", in_ready, 0);
            check("flush_write_ready", write_ready, 0);
            check("flush_conflict", conflict, 0);
            in_valid    = 2'b00;
            write_valid = 1'b0;
         end
         tick();
         n++;
      end
      check("flush_sweep_len", n, 64);
      lookup(1, mk(21'h0ABC, 7'd9), 4'hA, 1'b0, 2'd0, 1'b0, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
